fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 stall  in  1  multdiv busy; when 1, PC and IF/ID register hold.
REQ-005 imem_q  in  32  instruction word at imem_addr, valid combinationally in the same cycle.
REQ-006 ctrl_J, ctrl_Jal, ctrl_Jr, ctrl_bne, ctrl_blt, ctrl_bex  in  1 each  decoded from the opcode output by the control decoder.
REQ-007 isNotEqual, isLessThan  in  1 each  ALU compare results for the ID-stage instruction.
REQ-008 rstatus_nz  in  1  1 when $r30 != 0.
REQ-009 jr_target  in  32  value of $rd for jr.
REQ-010 imem_addr  out  12  = pc[11:0].
REQ-011 instr  out  32  IF/ID instruction register.
REQ-012 opcode  out  5  = instr[31:27], fed to the control decoder.
REQ-013 id_pc_plus1  out  32  IF/ID PC + 1, the jal link value for $r31.
REQ-014 id_valid  out  1  1 when instr holds a real (non-bubble) instruction.

Function
REQ-015 State SHALL be: pc[31:0], instr[31:0], id_pc[31:0], id_valid.
REQ-016 Redirect SHALL be evaluated only when id_valid=1 and stall=0.
REQ-017 Redirect priority (highest first): (ctrl_J|ctrl_Jal) > ctrl_Jr > (ctrl_bex & rstatus_nz) > (ctrl_bne & isNotEqual) > (ctrl_blt & isLessThan).
REQ-018 J/Jal/bex target SHALL be {5'b0, instr[26:0]}.
REQ-019 Jr target SHALL be jr_target.
REQ-020 bne/blt target SHALL be id_pc + 1 + sign-extended instr[16:0], modulo 2^32.
REQ-021 Not-taken bne/blt and non-redirecting bex SHALL behave as sequential flow.
REQ-022 Sequential flow (stall=0, no redirect): pc <= pc+1 (wraps 0xFFFFFFFF->0); instr <= imem_q; id_pc <= pc; id_valid <= 1.
REQ-023 Redirect (stall=0): pc <= target; instr <= 0; id_pc <= 0; id_valid <= 0 (one-cycle bubble flushing the wrong-path fetch).
REQ-024 Stall=1: pc, instr, id_pc and id_valid SHALL all hold; redirect is deferred and re-evaluated from the held ID state once stall falls.
REQ-025 Redirect latency: the target instruction SHALL appear in instr two rising edges after the redirecting instruction enters IF/ID with stall=0.
REQ-026 id_pc_plus1 SHALL be combinational id_pc + 1, modulo 2^32.
REQ-027 A bubble (id_valid=0) SHALL never cause a redirect, whatever the ctrl_* inputs are.
REQ-028 A redirect target equal to the current pc SHALL still insert the bubble.

Reset
REQ-029 On reset=1, asynchronously: pc=0, instr=0, id_pc=0, id_valid=0, hence imem_addr=0, opcode=0, id_pc_plus1=1.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL override both; the first fetch after reset deassertion SHALL be from address 0.

Verification
REQ-031 Sequential: reset, then imem returns 0x28000000+addr; after 3 edges -> pc=3, id_pc=2, instr=0x28000002, id_valid=1.
REQ-032 Jump: ID holds j with instr[26:0]=0x40 and ctrl_J=1 -> next edge pc=0x40, id_valid=0; the following edge instr=imem[0x40], id_pc=0x40.
REQ-033 Branch: id_pc=10, bne with imm=0x1FFFC (-4), isNotEqual=1 -> pc=7 and bubble; with isNotEqual=0 -> pc increments and no bubble.
REQ-034 Stall: hold stall=1 for 5 edges while ctrl_Jr=1 and jr_target=0x123 -> pc, instr and id_valid unchanged; first edge after stall=0 -> pc=0x123.
REQ-035 Priority/bubble: ctrl_J=1 and ctrl_bne=1 with isNotEqual=1 -> J target taken; the same inputs with id_valid=0 -> no redirect.
REQ-036 Async reset: assert reset between edges during a redirect -> outputs clear before the next edge; pc=0xFFFFFFFF sequential fetch -> pc wraps to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage with an IF/ID pipeline register. Jumps and taken branches are
// resolved in ID, redirect the PC and replace the wrong-path fetch with a bubble.
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] imem_q,
  input  logic        ctrl_J,
  input  logic        ctrl_Jal,
  input  logic        ctrl_Jr,
  input  logic        ctrl_bne,
  input  logic        ctrl_blt,
  input  logic        ctrl_bex,
  input  logic        isNotEqual,
  input  logic        isLessThan,
  input  logic        rstatus_nz,
  input  logic [31:0] jr_target,
  output logic [11:0] imem_addr,
  output logic [31:0] instr,
  output logic [4:0]  opcode,
  output logic [31:0] id_pc_plus1,
  output logic        id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] branch_target;

  assign branch_target = id_pc_q + 32'd1 + {{15{instr_q[16]}}, instr_q[16:0]};

  // Only a real instruction in ID, with the pipeline moving, may redirect.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    redirect        = 1'b0;
    redirect_target = '0;
    if (id_valid_q && !stall) begin
      if (ctrl_J || ctrl_Jal) begin
        redirect        = 1'b1;
        redirect_target = {5'b0, instr_q[26:0]};
      end else if (ctrl_Jr) begin
        redirect        = 1'b1;
        redirect_target = jr_target;
      end else if (ctrl_bex && rstatus_nz) begin
        redirect        = 1'b1;
        redirect_target = {5'b0, instr_q[26:0]};
      end else if (ctrl_bne && isNotEqual) begin
        redirect        = 1'b1;
        redirect_target = branch_target;
      end else if (ctrl_blt && isLessThan) begin
        redirect        = 1'b1;
        redirect_target = branch_target;
      end
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (!stall) begin
      if (redirect) begin
        pc_d       = redirect_target;
        instr_d    = '0;
        id_pc_d    = '0;
        id_valid_d = 1'b0;
      end else begin
        pc_d       = pc_q + 32'd1;
        instr_d    = imem_q;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      instr_q    <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr   = pc_q[11:0];
  assign instr       = instr_q;
  assign opcode      = instr_q[31:27];
  assign id_pc_plus1 = id_pc_q + 32'd1;
  assign id_valid    = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural model pushes expected
// IF/ID state into a scoreboard each cycle, popped and compared after the edge.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] imem_q;
  logic        ctrl_J, ctrl_Jal, ctrl_Jr, ctrl_bne, ctrl_blt, ctrl_bex;
  logic        isNotEqual, isLessThan, rstatus_nz;
  logic [31:0] jr_target;
  logic [11:0] imem_addr;
  logic [31:0] instr;
  logic [4:0]  opcode;
  logic [31:0] id_pc_plus1;
  logic        id_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] idpc;
    logic        valid;
  } state_t;

  state_t m;
  state_t sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .imem_q      (imem_q),
    .ctrl_J      (ctrl_J),
    .ctrl_Jal    (ctrl_Jal),
    .ctrl_Jr     (ctrl_Jr),
    .ctrl_bne    (ctrl_bne),
    .ctrl_blt    (ctrl_blt),
    .ctrl_bex    (ctrl_bex),
    .isNotEqual  (isNotEqual),
    .isLessThan  (isLessThan),
    .rstatus_nz  (rstatus_nz),
    .jr_target   (jr_target),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .opcode      (opcode),
    .id_pc_plus1 (id_pc_plus1),
    .id_valid    (id_valid)
  );

  always #5 clock = ~clock;

  // Instruction memory: a j to 0x40 at 5, a bne with imm -4 at 10, else 0x28000000+addr.
  function automatic logic [31:0] imem_fn(logic [11:0] a);
    case (a)
      12'd5:   return 32'h0800_0040;
      12'd10:  return 32'h1001_FFFC;
      default: return 32'h2800_0000 + {20'd0, a};
    endcase
  endfunction

  assign imem_q = imem_fn(imem_addr);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic state_t model(state_t s, logic [31:0] q);
    state_t      n;
    logic        redir;
    logic [31:0] tgt, bt;
    n     = s;
    redir = 1'b0;
    tgt   = '0;
    bt    = s.idpc + 32'd1 + {{15{s.instr[16]}}, s.instr[16:0]};
    if (!stall) begin
      if (s.valid) begin
        if (ctrl_J || ctrl_Jal)          begin redir = 1'b1; tgt = {5'b0, s.instr[26:0]}; end
        else if (ctrl_Jr)                begin redir = 1'b1; tgt = jr_target; end
        else if (ctrl_bex && rstatus_nz) begin redir = 1'b1; tgt = {5'b0, s.instr[26:0]}; end
        else if (ctrl_bne && isNotEqual) begin redir = 1'b1; tgt = bt; end
        else if (ctrl_blt && isLessThan) begin redir = 1'b1; tgt = bt; end
      end
      if (redir) n = '{pc: tgt, instr: 32'd0, idpc: 32'd0, valid: 1'b0};
      else       n = '{pc: s.pc + 32'd1, instr: q, idpc: s.pc, valid: 1'b1};
    end
    return n;
  endfunction

  task automatic compare_pop();
    state_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("imem_addr",   {20'd0, imem_addr}, {20'd0, e.pc[11:0]});
      check("instr",       instr, e.instr);
      check("opcode",      {27'd0, opcode}, {27'd0, e.instr[31:27]});
      check("id_pc_plus1", id_pc_plus1, e.idpc + 32'd1);
      check("id_valid",    {31'd0, id_valid}, {31'd0, e.valid});
      m = e;
    end
  endtask

  // One clock: predict from the current inputs, push, clock, pop and compare.
  task automatic step();
    sb.push_back(model(m, imem_fn(m.pc[11:0])));
    @(posedge clock);
    #1;
    compare_pop();
  endtask

  task automatic clear_ctrl();
    {ctrl_J, ctrl_Jal, ctrl_Jr, ctrl_bne, ctrl_blt, ctrl_bex} = '0;
    {isNotEqual, isLessThan, rstatus_nz} = '0;
    jr_target = '0;
    stall     = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_addr"},  {20'd0, imem_addr}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_op"},    {27'd0, opcode}, 32'd0);
    check({tag, "_plus1"}, id_pc_plus1, 32'd1);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
  endtask

  task automatic model_reset();
    m = '0;
    sb.delete();
  endtask

  initial begin
    logic [11:0] held_addr;
    logic [31:0] held_instr;
    reset = 1'b1;
    clear_ctrl();
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // Sequential flow
    repeat (3) step();
    check("seq_pc",    {20'd0, imem_addr}, 32'd3);
    check("seq_idpc",  id_pc_plus1, 32'd3);
    check("seq_instr", instr, 32'h2800_0002);
    check("seq_valid", {31'd0, id_valid}, 32'd1);

    // Jump with a lower-priority bne also asserted
    repeat (3) step();
    check("j_in_id", instr, 32'h0800_0040);
    ctrl_J = 1'b1; ctrl_bne = 1'b1; isNotEqual = 1'b1;
    step();
    check("j_pc",     {20'd0, imem_addr}, 32'h40);
    check("j_bubble", {31'd0, id_valid}, 32'd0);
    step();  // bubble in ID: same ctrl inputs must not redirect
    check("j_target_instr", instr, 32'h2800_0040);
    check("j_target_idpc",  id_pc_plus1, 32'h41);
    check("bubble_no_redir", {20'd0, imem_addr}, 32'h41);
    clear_ctrl();

    // bne not taken, then taken
    ctrl_Jr = 1'b1; jr_target = 32'd10;
    step();
    clear_ctrl();
    step();
    check("bne_in_id", instr, 32'h1001_FFFC);
    ctrl_bne = 1'b1; isNotEqual = 1'b0;
    step();
    check("bne_nt_pc",    {20'd0, imem_addr}, 32'd12);
    check("bne_nt_valid", {31'd0, id_valid}, 32'd1);
    clear_ctrl();
    ctrl_Jr = 1'b1; jr_target = 32'd10;
    step();
    clear_ctrl();
    step();
    ctrl_bne = 1'b1; isNotEqual = 1'b1;
    step();
    check("bne_t_pc",    {20'd0, imem_addr}, 32'd7);
    check("bne_t_valid", {31'd0, id_valid}, 32'd0);
    clear_ctrl();

    // Stall holds state and defers jr
    step();
    held_addr  = imem_addr;
    held_instr = instr;
    stall = 1'b1; ctrl_Jr = 1'b1; jr_target = 32'h123;
    repeat (5) step();
    check("stall_addr",  {20'd0, imem_addr}, {20'd0, held_addr});
    check("stall_instr", instr, held_instr);
    check("stall_valid", {31'd0, id_valid}, 32'd1);
    stall = 1'b0;
    step();
    check("jr_after_stall", {20'd0, imem_addr}, 32'h123);
    clear_ctrl();

    // Target equal to current pc still bubbles
    step();
    ctrl_Jr = 1'b1; jr_target = m.pc;
    step();
    check("self_target_bubble", {31'd0, id_valid}, 32'd0);
    clear_ctrl();

    // PC wrap 0xFFFFFFFF -> 0
    step();
    ctrl_Jr = 1'b1; jr_target = 32'hFFFF_FFFF;
    step();
    clear_ctrl();
    step();
    check("wrap_pc",    {20'd0, imem_addr}, 32'd0);
    check("wrap_plus1", id_pc_plus1, 32'd0);

    // Randomised mix of control, compares and stall
    for (int i = 0; i < 300; i++) begin
      {ctrl_J, ctrl_Jal, ctrl_Jr, ctrl_bne, ctrl_blt, ctrl_bex} = 6'($urandom) & 6'($urandom);
      {isNotEqual, isLessThan, rstatus_nz} = 3'($urandom);
      jr_target = $urandom_range(0, 4095);
      stall     = ($urandom_range(0, 3) == 0);
      step();
    end
    clear_ctrl();

    // Asynchronous reset between edges during a stalled redirect
    step();
    ctrl_J = 1'b1; stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    clear_ctrl();
    #2 reset = 1'b0;
    step();
    check("post_reset_fetch", instr, 32'h2800_0000);
    check("post_reset_pc",    {20'd0, imem_addr}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
